// File: rtl/libv_base_sacc.sv
// Saturating accumulator: sums N accepted samples per window with per-step clamping
// in unsigned or two's-complement mode, then emits one registered result and sticky flag.
module libv_base_sacc #(
    parameter int AW   = 5,
    parameter int OW   = 6,
    parameter int N    = 4,
    parameter     MODE = "UNS"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [AW-1:0] in_dat,
    output logic          out_vld,
    output logic [OW-1:0] out_dat,
    output logic          out_sat
);

    localparam int   CW  = (N > 1) ? $clog2(N) : 1;
    localparam logic SGN = (MODE == "SGN");

    if (!(MODE == "UNS" || MODE == "SGN")) begin : g_bad_mode
        $error("libv_base_sacc: MODE must be \"UNS\" or \"SGN\"");
    end
    if (AW < 1 || OW < AW || N < 1) begin : g_bad_size
        $error("libv_base_sacc: require AW >= 1, OW >= AW, N >= 1");
    end

    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_st_q, sat_st_d;
    logic          out_vld_q, out_vld_d;
    logic [OW-1:0] out_dat_q, out_dat_d;
    logic          out_sat_q, out_sat_d;

    logic [OW:0]   in_ext;
    logic [OW:0]   acc_ext;
    logic [OW:0]   sum;
    logic [OW-1:0] res;
    logic          clamp;

    // Sum at OW+1 bits, then clamp back to the OW-bit rail for the selected mode.
    always_comb begin
        in_ext  = SGN ? {{(OW+1-AW){in_dat[AW-1]}}, in_dat} : {{(OW+1-AW){1'b0}}, in_dat};
        acc_ext = SGN ? {acc_q[OW-1], acc_q} : {1'b0, acc_q};
        sum     = acc_ext + in_ext;
        clamp   = 1'b0;
        res     = sum[OW-1:0];
        if (SGN) begin
            if (sum[OW] != sum[OW-1]) begin
                clamp = 1'b1;
                res   = sum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            end
        end else if (sum[OW]) begin
            clamp = 1'b1;
            res   = {OW{1'b1}};
        end
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_st_d  = sat_st_q;
        out_dat_d = out_dat_q;
        out_sat_d = out_sat_q;
        out_vld_d = 1'b0;
        if (clr) begin
            acc_d    = '0;
            cnt_d    = '0;
            sat_st_d = 1'b0;
        end else if (ena && in_vld) begin
            if (cnt_q == CW'(N-1)) begin
                out_dat_d = res;
                out_sat_d = sat_st_q | clamp;
                out_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                sat_st_d  = 1'b0;
            end else begin
                acc_d    = res;
                cnt_d    = cnt_q + CW'(1);
                sat_st_d = sat_st_q | clamp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_st_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_st_q  <= sat_st_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;
    assign out_sat = out_sat_q;

endmodule

// File: tb/tb_libv_base_sacc.sv
// Bench for libv_base_sacc: an unsigned and a signed instance share stimulus;
// window results are queued as stimulus is driven and popped when out_vld pulses.
module tb_libv_base_sacc;

    logic       clk = 1'b0;
    logic       rst, ena, clr, uns_vld, sgn_vld;
    logic [4:0] in_dat;
    logic       uns_out_vld, uns_out_sat, sgn_out_vld, sgn_out_sat;
    logic [5:0] uns_out_dat, sgn_out_dat;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0] dat;
        logic       sat;
    } res_t;

    res_t uns_exp[$];
    res_t sgn_exp[$];

    libv_base_sacc #(.AW(5), .OW(6), .N(4), .MODE("UNS")) u_uns (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .in_vld(uns_vld), .in_dat(in_dat),
        .out_vld(uns_out_vld), .out_dat(uns_out_dat), .out_sat(uns_out_sat)
    );

    libv_base_sacc #(.AW(5), .OW(6), .N(4), .MODE("SGN")) u_sgn (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .in_vld(sgn_vld), .in_dat(in_dat),
        .out_vld(sgn_out_vld), .out_dat(sgn_out_dat), .out_sat(sgn_out_sat)
    );

    always #5 clk = ~clk;

    // One comparison with its failure report.
    task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge so the rising edge sees stable values.
    task automatic applyStimulus(input logic e, input logic r, input logic c,
                                 input logic uv, input logic sv, input logic [4:0] d);
        @(negedge clk);
        ena     = e;
        rst     = r;
        clr     = c;
        uns_vld = uv;
        sgn_vld = sv;
        in_dat  = d;
    endtask

    task automatic uns(input logic [4:0] d);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic sgn(input logic [4:0] d);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    function automatic res_t mk(input logic [5:0] d, input logic s);
        res_t r;
        r.dat = d;
        r.sat = s;
        return r;
    endfunction

    // Every out_vld sample must match the oldest queued result; a pulse with nothing queued fails.
    always @(negedge clk) begin
        res_t e;
        if (uns_out_vld === 1'b1) begin
            checks++;
            assert (uns_exp.size() != 0) else begin
                failures++;
                $error("[TB] FAIL uns_pulse observed=pulse expected=no_pulse");
            end
            if (uns_exp.size() != 0) begin
                e = uns_exp.pop_front();
                checkOutput("uns_dat", uns_out_dat, e.dat);
                checkOutput("uns_sat", {5'd0, uns_out_sat}, {5'd0, e.sat});
            end
        end
        if (sgn_out_vld === 1'b1) begin
            checks++;
            assert (sgn_exp.size() != 0) else begin
                failures++;
                $error("[TB] FAIL sgn_pulse observed=pulse expected=no_pulse");
            end
            if (sgn_exp.size() != 0) begin
                e = sgn_exp.pop_front();
                checkOutput("sgn_dat", sgn_out_dat, e.dat);
                checkOutput("sgn_sat", {5'd0, sgn_out_sat}, {5'd0, e.sat});
            end
        end
    end

    initial begin
        rst = 1'b0; ena = 1'b0; clr = 1'b0; uns_vld = 1'b0; sgn_vld = 1'b0; in_dat = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
        idle(1);
        checkOutput("rst_uns_vld", {5'd0, uns_out_vld}, 6'd0);
        checkOutput("rst_uns_dat", uns_out_dat, 6'd0);
        checkOutput("rst_uns_sat", {5'd0, uns_out_sat}, 6'd0);
        checkOutput("rst_sgn_vld", {5'd0, sgn_out_vld}, 6'd0);
        checkOutput("rst_sgn_dat", sgn_out_dat, 6'd0);
        checkOutput("rst_sgn_sat", {5'd0, sgn_out_sat}, 6'd0);

        $display("[TB] unsigned windows");
        uns_exp.push_back(mk(6'd63, 1'b0));
        uns(5'd31); uns(5'd31); uns(5'd1); uns(5'd0);
        uns_exp.push_back(mk(6'd63, 1'b1));
        uns(5'd31); uns(5'd31); uns(5'd31); uns(5'd0);
        uns_exp.push_back(mk(6'd10, 1'b0));
        uns(5'd1); uns(5'd2); uns(5'd3); uns(5'd4);
        idle(2);

        $display("[TB] signed windows");
        sgn_exp.push_back(mk(6'b101111, 1'b1));
        sgn(5'h10); sgn(5'h10); sgn(5'h10); sgn(5'h0F);
        sgn_exp.push_back(mk(6'd31, 1'b1));
        sgn(5'h0F); sgn(5'h0F); sgn(5'h0F); sgn(5'h0F);
        sgn_exp.push_back(mk(6'b111100, 1'b0));
        sgn(5'h1F); sgn(5'h1F); sgn(5'h1F); sgn(5'h1F);
        idle(2);

        $display("[TB] clock-enable gating");
        uns_exp.push_back(mk(6'd10, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd31);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'(i));
        end
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);
        idle(1);

        $display("[TB] window abort");
        uns(5'd5); uns(5'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
        uns_exp.push_back(mk(6'd4, 1'b0));
        uns(5'd1); uns(5'd1); uns(5'd1); uns(5'd1);
        idle(1);

        $display("[TB] mid-window reset");
        uns(5'd5); uns(5'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("mid_rst_dat", uns_out_dat, 6'd0);
        checkOutput("mid_rst_vld", {5'd0, uns_out_vld}, 6'd0);
        uns_exp.push_back(mk(6'd8, 1'b0));
        uns(5'd2); uns(5'd2); uns(5'd2); uns(5'd2);
        idle(3);

        checkOutput("uns_pending", 6'(uns_exp.size()), 6'd0);
        checkOutput("sgn_pending", 6'(sgn_exp.size()), 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
